// File: rtl/agc_fetch_pkg.sv
// Shared types and constants for the AGC instruction fetch unit.
// Fetch FSM encodings, the EXTEND prefix opcode and the decode-register layout.
package agc_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_RUN  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  localparam logic [14:0] EXTEND_OP = 15'o00006;

  localparam int REG_W = 28;

  typedef struct packed {
    logic [14:0] instr;
    logic [11:0] pc;
    logic        extend;
  } reg_t;

  typedef struct packed {
    logic        taken;
    logic [11:0] target;
  } branch_t;

  typedef struct packed {
    logic req;
    logic is_ext;
    logic load;
    logic to_out;
    logic to_hold;
    logic pop;
  } ctrl_t;

  function automatic logic [11:0] pc_inc(input logic [11:0] pc);
    return pc + 12'd1;
  endfunction

endpackage

// File: rtl/agc_fetch_reg.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
// Used for the fetch pc and the single-entry decode hold buffer.
module agc_fetch_reg #(
  parameter int               WIDTH     = 28,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/agc_fetch.sv
// AGC fetch unit: one outstanding memory request, EXTEND prefix folding,
// decode output register backed by a one-entry hold buffer for stall.
//
// state | meaning
// RUN   | no request outstanding; issue next fetch when hold buffer is empty
// WAIT  | one request outstanding, response will be used
// DROP  | one request outstanding, response squashed by a flush
module agc_fetch
  import agc_fetch_pkg::*;
#(
  parameter logic [11:0] RESET_PC    = 12'o4000,
  parameter logic [14:0] EXTEND_WORD = EXTEND_OP
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        stall,
  input  logic        flush,
  input  logic [11:0] branch_target,
  output logic        imem_req,
  output logic [11:0] imem_addr,
  input  logic        imem_ack,
  input  logic [14:0] imem_rdata,
  output logic        valid_D,
  output logic [14:0] instr_D,
  output logic [11:0] pc_D,
  output logic        extend_D
);

  localparam logic [1:0] S_RUN  = FETCH_RUN;
  localparam logic [1:0] S_WAIT = FETCH_WAIT;
  localparam logic [1:0] S_DROP = FETCH_DROP;

  logic [1:0]  state, state_nxt;
  logic [11:0] pc, pc_nxt, req_pc;
  logic        pc_en;
  logic        ext_pending;
  logic        hold_valid;
  logic        valid_q;
  reg_t        hold_q, incoming, out_q;
  branch_t     br;
  ctrl_t       ctrl;

  assign br       = '{taken: flush, target: branch_target};
  assign incoming = '{instr: imem_rdata, pc: req_pc, extend: ext_pending};

  // Requests are combinational so a 1-cycle memory sustains one word per 2 cycles.
  always_comb begin
    ctrl         = '0;
    ctrl.req     = rst_l && !br.taken && (state == S_RUN) && !hold_valid;
    ctrl.is_ext  = (imem_rdata == EXTEND_WORD);
    ctrl.load    = !br.taken && (state == S_WAIT) && imem_ack && !ctrl.is_ext;
    ctrl.pop     = !br.taken && !stall && hold_valid;
    ctrl.to_hold = ctrl.load && (stall ? valid_q : hold_valid);
    ctrl.to_out  = ctrl.load && !ctrl.to_hold;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (ctrl.req) state_nxt = S_WAIT;
      S_WAIT: begin
        if (br.taken)     state_nxt = S_DROP;
        else if (imem_ack) state_nxt = S_RUN;
      end
      S_DROP:  if (!br.taken && imem_ack) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  assign pc_en  = br.taken || ctrl.req;
  assign pc_nxt = br.taken ? br.target : pc_inc(pc);

  agc_fetch_reg #(
    .WIDTH    (12),
    .RESET_VAL(RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst_l(rst_l),
    .en   (pc_en),
    .d    (pc_nxt),
    .q    (pc)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      req_pc <= '0;
    end else if (ctrl.req) begin
      req_pc <= pc;
    end
  end

  // An EXTEND response arms the flag; the next kept response consumes it.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ext_pending <= 1'b0;
    end else if (br.taken) begin
      ext_pending <= 1'b0;
    end else if ((state == S_WAIT) && imem_ack) begin
      ext_pending <= ctrl.is_ext;
    end
  end

  agc_fetch_reg #(
    .WIDTH    (REG_W),
    .RESET_VAL('0)
  ) u_hold (
    .clk  (clk),
    .rst_l(rst_l),
    .en   (ctrl.to_hold),
    .d    (incoming),
    .q    (hold_q)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      hold_valid <= 1'b0;
    end else if (br.taken) begin
      hold_valid <= 1'b0;
    end else if (ctrl.to_hold) begin
      hold_valid <= 1'b1;
    end else if (ctrl.pop) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (br.taken) begin
      valid_q <= 1'b0;
    end else if (ctrl.to_out) begin
      valid_q <= 1'b1;
      out_q   <= incoming;
    end else if (ctrl.pop) begin
      valid_q <= 1'b1;
      out_q   <= hold_q;
    end else if (!stall) begin
      valid_q <= 1'b0;
    end
  end

  assign imem_req  = ctrl.req;
  assign imem_addr = ctrl.req ? pc : '0;
  assign valid_D   = valid_q;
  assign instr_D   = out_q.instr;
  assign pc_D      = out_q.pc;
  assign extend_D  = out_q.extend;

endmodule

// File: tb/tb_agc_fetch.sv
// Self-checking bench for agc_fetch: memory model plus delivery scoreboard,
// directed cases for reset, EXTEND folding, stall, flush, wrap and throughput.
module tb_agc_fetch;

  localparam logic [14:0] EXT = 15'o00006;

  typedef struct packed {
    logic [14:0] instr;
    logic [11:0] pc;
    logic        ext;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [11:0] branch_target = '0;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [14:0] imem_rdata = '0;
  logic        valid_D;
  logic [14:0] instr_D;
  logic [11:0] pc_D;
  logic        extend_D;

  agc_fetch dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .stall        (stall),
    .flush        (flush),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .valid_D      (valid_D),
    .instr_D      (instr_D),
    .pc_D         (pc_D),
    .extend_D     (extend_D)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [14:0] mem [4096];
  exp_t        sb[$];

  logic [11:0] model_pc;
  logic        model_ext;
  logic        kept;
  logic        pending;
  logic        ack_real;
  int          cnt;
  int          lat;
  bit          rand_lat;
  logic [11:0] pend_addr;
  logic [11:0] ack_addr;
  int          n_cons;

  logic        o_req, o_valid, o_ext, o_ack_real;
  logic [11:0] o_addr, o_pc;
  logic [14:0] o_instr;
  logic        p_valid, p_stall, p_flush, p_ext;
  logic [11:0] p_pc;
  logic [14:0] p_instr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0o exp=%0o t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic observe();
    exp_t e;
    o_req = imem_req; o_addr = imem_addr; o_valid = valid_D;
    o_instr = instr_D; o_pc = pc_D; o_ext = extend_D;
    o_ack_real = imem_ack && ack_real;
    if (sb.size() >= 2) chk("req_while_full", imem_req, 0);
    if (flush) chk("req_on_flush", imem_req, 0);
    if (imem_req) begin
      chk("one_outstanding", pending, 0);
      chk("imem_addr", imem_addr, model_pc);
      pend_addr = model_pc;
      model_pc  = model_pc + 12'd1;
      pending   = 1'b1;
      kept      = 1'b1;
      cnt       = rand_lat ? int'($urandom_range(1, 3)) : lat;
    end
    if (p_stall && !p_flush && p_valid) begin
      chk("hold_valid", valid_D, p_valid);
      chk("hold_instr", instr_D, p_instr);
      chk("hold_pc", pc_D, p_pc);
      chk("hold_ext", extend_D, p_ext);
    end
    if (flush) begin
      sb.delete();
      model_ext = 1'b0;
      kept      = 1'b0;
      model_pc  = branch_target;
    end else if (!stall && valid_D) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", valid_D, 0);
      end else begin
        e = sb.pop_front();
        chk("deliv_instr", instr_D, e.instr);
        chk("deliv_pc", pc_D, e.pc);
        chk("deliv_ext", extend_D, e.ext);
        n_cons++;
      end
    end
    if (imem_ack && ack_real) begin
      ack_addr = pend_addr;
      if (kept) begin
        if (mem[pend_addr] == EXT) begin
          model_ext = 1'b1;
        end else begin
          sb.push_back('{instr: mem[pend_addr], pc: pend_addr, ext: model_ext});
          model_ext = 1'b0;
        end
        kept = 1'b0;
      end
    end
    p_valid = valid_D; p_instr = instr_D; p_pc = pc_D; p_ext = extend_D;
    p_stall = stall; p_flush = flush;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    ack_real = 1'b0;
    if (pending) begin
      cnt--;
      if (cnt <= 0) begin
        imem_ack   = 1'b1;
        ack_real   = 1'b1;
        imem_rdata = mem[pend_addr];
        pending    = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input bit stale);
    rst_l = 1'b0; stall = 1'b0; flush = 1'b0;
    imem_ack = 1'b0; ack_real = 1'b0; pending = 1'b0; kept = 1'b0;
    model_ext = 1'b0; sb.delete(); model_pc = 12'o4000;
    lat = 1; rand_lat = 1'b0;
    p_valid = 1'b0; p_stall = 1'b0; p_flush = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid_D, 0);
    chk("rst_instr", instr_D, 0);
    chk("rst_pc", pc_D, 0);
    chk("rst_ext", extend_D, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    if (stale) begin
      imem_ack   = 1'b1;
      imem_rdata = 15'o11111;
    end
  endtask

  task automatic do_flush(input logic [11:0] t);
    int n = 0;
    while (imem_ack && n < 10) begin
      tick();
      n++;
    end
    chk("flush_slot", imem_ack, 0);
    flush = 1'b1;
    branch_target = t;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    bit found = 0;
    for (int i = 0; i < 40; i++) if (!found) begin tick(); found = o_req; end
    chk(tag, found, 1);
  endtask

  task automatic wait_req_addr(input logic [11:0] a, input string tag);
    bit found = 0;
    for (int i = 0; i < 40; i++) if (!found) begin tick(); found = o_req && (o_addr == a); end
    chk(tag, found, 1);
  endtask

  task automatic wait_ack(input string tag);
    bit found = 0;
    for (int i = 0; i < 40; i++) if (!found) begin tick(); found = o_ack_real; end
    chk(tag, found, 1);
  endtask

  task automatic wait_valid(input string tag);
    bit found = 0;
    for (int i = 0; i < 40; i++) if (!found) begin tick(); found = o_valid; end
    chk(tag, found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] nxt;
    int          c0;
    n_cons = 0;
    for (int a = 0; a < 4096; a++) mem[a] = 15'o30000 | 15'(a);
    mem[12'o4000] = 15'o30001;
    mem[12'o4001] = EXT;
    mem[12'o4002] = 15'o10100;
    mem[12'o3000] = EXT;

    // reset release, first fetch and EXTEND folding
    do_reset(0);
    tick();
    chk("c1_req", o_req, 1);
    chk("c1_addr", o_addr, 12'o4000);
    tick();
    tick();
    chk("c3_valid", o_valid, 1);
    chk("c3_instr", o_instr, 15'o30001);
    chk("c3_pc", o_pc, 12'o4000);
    chk("c3_ext", o_ext, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("c7_valid", o_valid, 1);
    chk("c7_instr", o_instr, 15'o10100);
    chk("c7_pc", o_pc, 12'o4002);
    chk("c7_ext", o_ext, 1);

    // stall for 3 cycles while the next response lands in the hold buffer
    wait_ack("wait_ack_stall");
    nxt = ack_addr + 12'd1;
    stall = 1'b1;
    tick();
    chk("stall_out_live", o_valid, 1);
    tick();
    tick();
    chk("stall_noreq", o_req, 0);
    stall = 1'b0;
    tick();
    chk("unstall_noreq", o_req, 0);
    tick();
    chk("buf_valid", o_valid, 1);
    chk("buf_pc", o_pc, nxt);

    // flush while waiting, response one cycle later is discarded
    lat = 2;
    wait_req("wait_req_flush");
    flush = 1'b1;
    branch_target = 12'o2000;
    tick();
    flush = 1'b0;
    chk("flush_noreq", o_req, 0);
    tick();
    chk("flush_valid", o_valid, 0);
    tick();
    chk("redirect_req", o_req, 1);
    chk("redirect_addr", o_addr, 12'o2000);
    lat = 1;

    // flush with ext_pending set
    do_flush(12'o3000);
    wait_req_addr(12'o3000, "wait_req_3000");
    tick();
    do_flush(12'o2100);
    wait_valid("wait_valid_2100");
    chk("post_flush_ext", o_ext, 0);
    chk("post_flush_pc", o_pc, 12'o2100);

    // pc wrap
    do_flush(12'o7776);
    wait_req_addr(12'o7777, "wait_req_7777");
    wait_req("wait_req_wrap");
    chk("wrap_addr", o_addr, 12'o0000);

    // throughput with 1-cycle memory
    c0 = n_cons;
    for (int i = 0; i < 21; i++) tick();
    chk("throughput", (n_cons - c0) >= 10, 1);

    // random stall, flush and latency
    rand_lat = 1'b1;
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      if (!imem_ack && $urandom_range(0, 29) == 0) begin
        flush = 1'b1;
        branch_target = 12'($urandom_range(0, 4095));
      end else begin
        flush = 1'b0;
      end
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
    rand_lat = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // reset while waiting, stale ack after release ignored
    lat = 3;
    wait_req("wait_req_rst");
    do_reset(1);
    tick();
    chk("rst2_req", o_req, 1);
    chk("rst2_addr", o_addr, 12'o4000);
    wait_valid("wait_valid_rst2");
    chk("rst2_instr", o_instr, 15'o30001);
    chk("rst2_pc", o_pc, 12'o4000);
    chk("rst2_ext", o_ext, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/agc_fetch.md
AGC_FETCH -- requirements
Module: agc_fetch

Interface
REQ-001 Parameter RESET_PC, default 12'o4000, SHALL be the address of the first fetch after reset.
REQ-002 Parameter EXTEND_WORD, default 15'o00006, SHALL be the prefix word that is folded into the following instruction.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_l  input  1  reset; asynchronous, active-low.
REQ-005 stall  input  1  decode hold; the output register SHALL keep its contents while stall=1.
REQ-006 flush  input  1  branch taken in execute; squashes in-flight fetch state.
REQ-007 branch_target  input  12  redirect address, sampled when flush=1.
REQ-008 imem_req  output  1  single-cycle request strobe.
REQ-009 imem_addr  output  12  request address, valid only when imem_req=1.
REQ-010 imem_ack  input  1  response strobe, arriving 1 or more cycles after imem_req.
REQ-011 imem_rdata  input  15  response word, valid only when imem_ack=1.
REQ-012 valid_D  output  1  decode output register holds a live instruction.
REQ-013 instr_D  output  15  instruction word.
REQ-014 pc_D  output  12  address of instr_D; for an EXTEND pair, the address of the second word.
REQ-015 extend_D  output  1  instr_D was preceded by EXTEND_WORD.

Function
REQ-016 The block SHALL implement FSM states RUN (no outstanding request), WAIT (one outstanding request, response kept) and DROP (one outstanding request, response discarded).
REQ-017 At most one request SHALL be outstanding.
REQ-018 In RUN with flush=0 and hold buffer empty, the block SHALL assert imem_req with imem_addr=pc, latch req_pc=pc, set pc=pc+1 mod 2^12 (12'o7777 wraps to 0), and go to WAIT.
REQ-019 In WAIT, when imem_ack=1 and imem_rdata=EXTEND_WORD, the block SHALL set ext_pending=1, deliver nothing, and go to RUN.
REQ-020 In WAIT, when imem_ack=1 with any other word, the word SHALL be loaded with pc_D=req_pc and extend_D=ext_pending, ext_pending SHALL clear, and the FSM SHALL go to RUN.
REQ-021 The load in REQ-020 SHALL target the output register if the slot is free (valid_D=0 or stall=0), otherwise the single-entry hold buffer.
REQ-022 When stall=0 and the hold buffer is full, the buffer SHALL move to the output register and empty.
REQ-023 When stall=0 and nothing is loaded that cycle, valid_D SHALL go to 0 (instruction consumed).
REQ-024 When stall=1, valid_D, instr_D, pc_D and extend_D SHALL hold.
REQ-025 flush SHALL override stall and every other event in the same cycle, with these effects: valid_D=0, hold buffer emptied, ext_pending=0, pc=branch_target, no imem_req that cycle.
REQ-026 On flush, the FSM SHALL go WAIT->DROP (also when imem_ack=1 in that same cycle, in which case that data is discarded) and RUN->RUN.
REQ-027 In DROP, an imem_ack SHALL be discarded and the FSM SHALL go to RUN; a further flush in DROP SHALL stay in DROP and reload pc.
REQ-028 Minimum throughput SHALL be one delivered instruction per 2 cycles with a 1-cycle memory.

Reset
REQ-029 While rst_l=0, the block SHALL set: pc=RESET_PC, state=RUN, ext_pending=0, hold buffer empty, valid_D=0, instr_D=0, pc_D=0, extend_D=0, imem_req=0, imem_addr=0.
REQ-030 Reset asserted in WAIT SHALL abandon the request; an ack arriving after release SHALL be ignored because the FSM is in RUN.

Structure
REQ-031 The fetch state enum and the EXTEND opcode constant SHALL live in the shared package with reg_t, branch_t and ctrl_t.
REQ-032 The hold buffer SHALL be a register sub-module instance (register, WIDTH=28: instr, pc, extend), and pc SHALL be a register instance with RESET_VAL=RESET_PC.

Verification
REQ-033 Reset release, 1-cycle memory returning 15'o30001 at 12'o4000 -> imem_req on cycle 1 with addr 12'o4000; valid_D=1, instr_D=15'o30001, pc_D=12'o4000, extend_D=0 on cycle 3.
REQ-034 Memory words 15'o00006 at 12'o4001, then 15'o10100 -> the EXTEND word is never delivered; one instruction is delivered with instr_D=15'o10100, pc_D=12'o4002, extend_D=1.
REQ-035 stall held 3 cycles while a response arrives -> output holds, buffer fills, no new imem_req; after stall falls, buffered word appears on the next cycle and no word is lost or duplicated.
REQ-036 flush with branch_target=12'o2000 in WAIT, with ack arriving the next cycle -> ack data discarded, valid_D=0, next imem_addr=12'o2000.
REQ-037 flush while ext_pending=1 -> the first instruction delivered from the target has extend_D=0.
REQ-038 pc=12'o7777 -> the following request uses imem_addr=12'o0000.
